// File: rtl/mem_pkg.sv
// Shared types and constants for the load/store front end (mem_access_unit).
package mem_pkg;

  localparam int RAM_WORD_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {IDLE, RD, CAP, MRG, WR, ERR, RESP} mau_state_e;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we)
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Clear the low byte-offset bits below the access size (size = funct3[1:0]).
  function automatic logic [1:0] align_offset(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    return off;
      2'd1:    return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: sub-word store merge and load lane extract/extend.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [RAM_WORD_W-1:0] old_word,
  input  logic [RAM_WORD_W-1:0] st_data,
  input  logic [RAM_WORD_W-1:0] ld_word,
  input  logic [2:0]            funct3,
  input  logic [1:0]            offset,
  output logic [RAM_WORD_W-1:0] merged,
  output logic [RAM_WORD_W-1:0] ld_data
);

  logic [3:0]            byte_en;
  logic [RAM_WORD_W-1:0] st_rep;
  logic [RAM_WORD_W-1:0] ld_shift;

  always_comb begin
    case (funct3[1:0])
      2'd0:    byte_en = 4'b0001 << offset;
      2'd1:    byte_en = 4'b0011 << offset;
      default: byte_en = 4'b1111;
    endcase
    case (funct3[1:0])
      2'd0:    st_rep = {4{st_data[7:0]}};
      2'd1:    st_rep = {2{st_data[15:0]}};
      default: st_rep = st_data;
    endcase
  end

  // Replicated store data lets each byte lane pick independently.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merged[8*gi +: 8] = byte_en[gi] ? st_rep[8*gi +: 8] : old_word[8*gi +: 8];
    end
  endgenerate

  assign ld_shift = ld_word >> {offset, 3'b000};

  always_comb begin
    case (funct3)
      F3_B:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      F3_BU:   ld_data = {24'h0, ld_shift[7:0]};
      F3_H:    ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      F3_HU:   ld_data = {16'h0, ld_shift[15:0]};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end mapping byte/half/word core accesses onto a word-only RAM.
// Optional: define MEM_ACCESS_MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int          ADDR_BITS = 14,
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  ram_wen,
  output logic                  ram_ren,
  output logic [ADDR_BITS-1:0]  ram_waddr,
  output logic [ADDR_BITS-1:0]  ram_raddr,
  output logic [RAM_WORD_W-1:0] ram_wdata,
  input  logic [RAM_WORD_W-1:0] ram_rdata
);

  mau_state_e            state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            offset_q, offset_d;
  logic [ADDR_BITS-1:0]  widx_q, widx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [RAM_WORD_W-1:0] cap_word_q, cap_word_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;

  logic                  in_window;
  logic                  misalign_fault;
  logic                  req_fault;
  logic [RAM_WORD_W-1:0] merged_word;
  logic [RAM_WORD_W-1:0] ld_data;

  // Window is aligned to its size, so membership is an upper-bit compare.
  assign in_window = (req_addr[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign misalign_fault = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                          ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'b00));
`else
  assign misalign_fault = 1'b0;
`endif

  assign req_fault = !in_window || !f3_legal(req_we, req_funct3) || misalign_fault;

  mem_lane_align u_lane (
    .old_word (cap_word_q),
    .st_data  (wdata_q),
    .ld_word  (ram_rdata),
    .funct3   (funct3_q),
    .offset   (offset_q),
    .merged   (merged_word),
    .ld_data  (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      offset_q     <= 2'b00;
      widx_q       <= '0;
      wdata_q      <= 32'h0;
      cap_word_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      offset_q     <= offset_d;
      widx_q       <= widx_d;
      wdata_q      <= wdata_d;
      cap_word_q   <= cap_word_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_fault)
            state_d = ERR;
          else if (req_we && (req_funct3[1:0] == 2'd2))
            state_d = WR;
          else
            state_d = RD;
        end
      end
      RD:   state_d = CAP;
      CAP:  state_d = we_q ? MRG : RESP;
      MRG:  state_d = RESP;
      WR:   state_d = RESP;
      // ERR already presents its response, so a same-cycle accept must not repeat it.
      ERR:  state_d = resp_ready ? IDLE : RESP;
      RESP: state_d = resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    we_d         = we_q;
    funct3_d     = funct3_q;
    offset_d     = offset_q;
    widx_d       = widx_q;
    wdata_d      = wdata_q;
    cap_word_d   = cap_word_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          offset_d = align_offset(req_funct3[1:0], req_addr[1:0]);
          widx_d   = req_fault ? '0 : req_addr[ADDR_BITS+1:2];
          wdata_d  = req_wdata;
          if (req_fault) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
          end
        end
      end
      CAP: begin
        cap_word_d = ram_rdata;
        if (!we_q) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = ld_data;
        end
      end
      MRG, WR: begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;
      end
      ERR, RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = 32'h0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE) && rst_n;
    ram_ren    = (state_q == RD);
    ram_wen    = (state_q == WR) || (state_q == MRG);
    ram_waddr  = widx_q;
    ram_raddr  = widx_q;
    ram_wdata  = '0;
    if (state_q == WR)
      ram_wdata = wdata_q;
    else if (state_q == MRG)
      ram_wdata = merged_word;
    resp_valid = resp_valid_q;
    resp_rdata = resp_rdata_q;
    resp_err   = resp_err_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus random accesses vs a byte-array model.
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int          AB    = 8;
  localparam int          WORDS = 1 << AB;
  localparam int          BYTES = 4 * WORDS;
  localparam logic [31:0] BASE  = 32'h0001_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'b000;
  logic [31:0]   req_addr = 32'h0;
  logic [31:0]   req_wdata = 32'h0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          ram_wen;
  logic          ram_ren;
  logic [AB-1:0] ram_waddr;
  logic [AB-1:0] ram_raddr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata = 32'h0;

  logic [31:0] ram [0:WORDS-1];
  logic [7:0]  ref_mem [0:BYTES-1];

  int n_assert = 0;
  int n_fail   = 0;

  int          n_ren, n_wen, first_ren, first_wen, resp_cyc;
  logic [31:0] got_rdata, wen_data;
  logic        got_err, both_strobes;
  logic [31:0] wen_addr, ren_addr;

  mem_access_unit #(.ADDR_BITS(AB), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .ram_wen    (ram_wen),
    .ram_ren    (ram_ren),
    .ram_waddr  (ram_waddr),
    .ram_raddr  (ram_raddr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;

  // Word RAM with one-cycle read latency
  always @(posedge clk) begin
    if (ram_wen) ram[ram_waddr] <= ram_wdata;
    if (ram_ren) ram_rdata <= ram[ram_raddr];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int idx, input logic [31:0] v);
    ram[idx] = v;
    for (int b = 0; b < 4; b++) ref_mem[4*idx + b] = v[8*b +: 8];
  endtask

  // Drives one request, follows it to the response handshake, records strobes and timing.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold);
    int cyc;
    @(negedge clk);
    check("accept_ready", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    n_ren = 0; n_wen = 0; first_ren = -1; first_wen = -1; resp_cyc = -1; cyc = 0;
    both_strobes = 1'b0; wen_data = 32'h0; wen_addr = 32'h0; ren_addr = 32'h0;
    got_rdata = 32'h0; got_err = 1'b0;
    while (resp_cyc < 0 && cyc < 20) begin
      @(negedge clk); cyc++;
      if (ram_ren) begin n_ren++; if (first_ren < 0) first_ren = cyc; ren_addr = 32'(ram_raddr); end
      if (ram_wen) begin n_wen++; first_wen = cyc; wen_addr = 32'(ram_waddr); wen_data = ram_wdata; end
      if (ram_ren && ram_wen) both_strobes = 1'b1;
      if (resp_valid) begin resp_cyc = cyc; got_rdata = resp_rdata; got_err = resp_err; end
    end
    if (resp_cyc < 0) begin
      check("resp_timeout", 32'(resp_valid), 32'h1);
      return;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_rdata", resp_rdata, got_rdata);
      check("hold_ctl", {28'h0, resp_valid, resp_err, req_ready, ram_wen | ram_ren},
            {28'h0, 1'b1, got_err, 1'b0, 1'b0});
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check("idle_after", {30'h0, req_ready, resp_valid}, 32'h2);
  endtask

  // Reference behaviour over a flat byte array; also checks the recorded transaction.
  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input int hold, input string tag);
    logic        err;
    logic [31:0] exp_rd, exp_word;
    longint      off, eff, sz;
    int          e_resp, e_ren, e_wen, e_fren, e_fwen;
    longint      v;
    sz  = 64'd1 << f3[1:0];
    off = longint'(addr) - longint'(BASE);
    err = (off < 0) || (off >= BYTES);
    if (we) err = err || (f3 > 3'd2);
    else    err = err || (f3 == 3'd3) || (f3 >= 3'd6);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    if (!err && (off % sz) != 0) err = 1'b1;
`endif
    eff = err ? 0 : off - (off % sz);
    exp_rd = 32'h0; exp_word = 32'h0;
    e_ren = 0; e_wen = 0; e_fren = -1; e_fwen = -1;
    if (err) begin
      e_resp = 1;
    end else if (!we) begin
      v = 0;
      for (int i = 0; i < sz; i++) v = v + (longint'(ref_mem[eff + i]) << (8 * i));
      if (!f3[2] && sz < 4 && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
      exp_rd = v[31:0];
      e_resp = 3; e_ren = 1; e_fren = 1;
    end else begin
      for (int i = 0; i < sz; i++) ref_mem[eff + i] = wd[8*i +: 8];
      for (int b = 0; b < 4; b++) exp_word[8*b +: 8] = ref_mem[(eff / 4) * 4 + b];
      if (sz == 4) begin e_resp = 2; e_wen = 1; e_fwen = 1; end
      else begin e_resp = 4; e_ren = 1; e_wen = 1; e_fren = 1; e_fwen = 3; end
    end
    do_req(we, f3, addr, wd, hold);
    check({tag, "_rdata"}, got_rdata, exp_rd);
    check({tag, "_err"}, 32'(got_err), 32'(err));
    check({tag, "_resp_cyc"}, 32'(resp_cyc), 32'(e_resp));
    check({tag, "_strobes"}, {n_ren[15:0], n_wen[15:0]}, {e_ren[15:0], e_wen[15:0]});
    check({tag, "_strobe_cyc"}, {first_ren[15:0], first_wen[15:0]}, {e_fren[15:0], e_fwen[15:0]});
    check({tag, "_both"}, 32'(both_strobes), 32'h0);
    if (e_ren > 0) check({tag, "_raddr"}, ren_addr, 32'(eff / 4));
    if (e_wen > 0) begin
      check({tag, "_waddr"}, wen_addr, 32'(eff / 4));
      check({tag, "_wdata"}, wen_data, exp_word);
    end
    $display("txn %-8s we=%0d f3=%0d addr=%h wd=%h -> rdata=%h err=%0d resp_cyc=%0d",
             tag, we, f3, addr, wd, got_rdata, got_err, resp_cyc);
  endtask

  task automatic check_quiet(input string tag, input logic exp_ready);
    check({tag, "_ctl"}, {27'h0, req_ready, resp_valid, resp_err, ram_wen, ram_ren},
          {27'h0, exp_ready, 4'b0000});
    check({tag, "_data"}, resp_rdata | ram_wdata | 32'(ram_waddr) | 32'(ram_raddr), 32'h0);
  endtask

  initial begin
    logic [31:0] old_w;
    int          r;
    logic [31:0] a;
    for (int i = 0; i < WORDS; i++) set_word(i, $urandom);

    // Reset state
    repeat (3) @(negedge clk);
    check_quiet("in_reset", 1'b0);
    rst_n = 1'b1;
    #1;
    check_quiet("after_reset", 1'b1);

    // Byte loads, signed and unsigned
    set_word(0, 32'h8899_AABB);
    run(1'b0, F3_B, BASE + 1, 32'h0, 0, "lb");
    check("t1_lb_const", got_rdata, 32'hFFFF_FFAA);
    run(1'b0, F3_BU, BASE + 1, 32'h0, 0, "lbu");
    check("t1_lbu_const", got_rdata, 32'h0000_00AA);

    // Word store
    run(1'b1, F3_W, BASE + 8, 32'hDEAD_BEEF, 0, "sw");
    check("t2_sw_word", wen_data, 32'hDEAD_BEEF);
    check("t2_sw_addr", wen_addr, 32'h2);

    // Half store via read-modify-write, then read back
    run(1'b1, F3_H, BASE + 10, 32'h0000_1234, 0, "sh");
    check("t3_sh_word", wen_data, 32'h1234_BEEF);
    run(1'b0, F3_W, BASE + 8, 32'h0, 0, "lw");
    check("t3_lw_const", got_rdata, 32'h1234_BEEF);

    // Misaligned word load
    run(1'b0, F3_W, BASE + 2, 32'h0, 0, "lw_mis");
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    check("t4_mis_err", 32'(got_err), 32'h1);
`else
    check("t4_mis_data", got_rdata, 32'h8899_AABB);
`endif

    // Faults: below window, above window, illegal funct3
    run(1'b0, F3_W, BASE - 4, 32'h0, 0, "lo_win");
    check("t5_lo_err", {31'h0, got_err}, 32'h1);
    run(1'b0, 3'd3, BASE + 4, 32'h0, 0, "bad_f3");
    check("t5_f3_err", {31'h0, got_err}, 32'h1);
    run(1'b0, F3_W, BASE + BYTES, 32'h0, 0, "hi_win");
    run(1'b0, F3_W, BASE + BYTES - 4, 32'h0, 0, "top_w");
    run(1'b1, F3_B, BASE + 4, 32'h0000_0055, 2, "err_st");
    run(1'b0, F3_H, BASE + 4, 32'h0, 3, "ld_hold");

    // Response held for 5 cycles
    run(1'b0, F3_W, BASE + 8, 32'h0, 5, "hold5");

    // Random traffic
    for (int t = 0; t < 80; t++) begin
      r = $urandom_range(0, 11);
      if (r == 0)      a = BASE - 32'($urandom_range(1, 16));
      else if (r == 1) a = BASE + BYTES + 32'($urandom_range(0, 15));
      else             a = BASE + 32'($urandom_range(0, BYTES - 1));
      run(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
          $urandom_range(0, 2), "rnd");
    end

    // Reset while an SB sits in MRG: the write must never land
    old_w = ram[3];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B; req_addr = BASE + 13; req_wdata = 32'h77;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("mrg_wen_before_rst", {31'h0, ram_wen}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_quiet("rst_in_mrg", 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("rst_no_write", ram[3], old_w);
    rst_n = 1'b1;
    #1;
    check_quiet("rst_release", 1'b1);
    $display("txn rst_mrg  word3=%h", ram[3]);

    // Still functional after the abort
    run(1'b0, F3_W, BASE + 12, 32'h0, 0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
